// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer: op codes,
// FSM state encoding and the shift-amount saturation helper.
package shift_pkg;

   localparam logic [2:0] OP_CLR  = 3'd0;
   localparam logic [2:0] OP_LOAD = 3'd1;
   localparam logic [2:0] OP_LSR  = 3'd2;
   localparam logic [2:0] OP_LSL  = 3'd3;
   localparam logic [2:0] OP_ASR  = 3'd4;
   localparam logic [2:0] OP_FILL = 3'd5;
   localparam logic [2:0] OP_ROR  = 3'd6;
   localparam logic [2:0] OP_ROL  = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   // Amounts beyond the word width clamp to the width itself.
   function automatic int unsigned sat_amt(
      input int unsigned amt,
      input int unsigned len
   );
      return (amt > len) ? len : amt;
   endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit shift step: combinational next value of the data
// register for the selected operation.
module shift_step
   import shift_pkg::*;
#(
   parameter int DATA_LEN = 8
) (
   input  logic [DATA_LEN-1:0] q_i,
   input  logic [2:0]          op_i,
   input  logic                fill_i,
   output logic [DATA_LEN-1:0] q_o
);

   // Select the single-step transform for the captured op.
   always_comb begin
      q_o = q_i;
      unique case (op_i)
         OP_CLR:  q_o = '0;
         OP_LOAD: q_o = q_i;
         OP_LSR:  q_o = {1'b0, q_i[DATA_LEN-1:1]};
         OP_LSL:  q_o = {q_i[DATA_LEN-2:0], 1'b0};
         OP_ASR:  q_o = {q_i[DATA_LEN-1], q_i[DATA_LEN-1:1]};
         OP_FILL: q_o = {fill_i, q_i[DATA_LEN-1:1]};
         OP_ROR:  q_o = {q_i[0], q_i[DATA_LEN-1:1]};
         OP_ROL:  q_o = {q_i[DATA_LEN-2:0], q_i[DATA_LEN-1]};
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-bit shift engine: accepts a request, applies one shift
// step per cycle for the saturated amount, returns the result.
module shift_sequencer
   import shift_pkg::*;
#(
   parameter int DATA_LEN = 8,
   parameter int AMT_W    = $clog2(DATA_LEN) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [DATA_LEN-1:0] req_data,
   input  logic [2:0]          req_op,
   input  logic [AMT_W-1:0]    req_amt,
   input  logic                req_fill,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_LEN-1:0] rsp_data,
   output logic                busy
);

   state_e              state_q, state_d;
   logic [DATA_LEN-1:0] data_q, data_d;
   logic [DATA_LEN-1:0] step_nxt;
   logic [2:0]          op_q, op_d;
   logic                fill_q, fill_d;
   logic [AMT_W-1:0]    cnt_q, cnt_d;
   logic                ready_q, ready_d;
   logic                valid_q, valid_d;
   logic                busy_q, busy_d;
   logic [AMT_W-1:0]    amt_eff;
   logic                zero_step;

   shift_step #(
      .DATA_LEN(DATA_LEN)
   ) u_step (
      .q_i   (step_in_q()),
      .op_i  (op_q),
      .fill_i(fill_q),
      .q_o   (step_nxt)
   );

   function automatic logic [DATA_LEN-1:0] step_in_q();
      return data_q;
   endfunction

   // Clamp the requested amount; clear/load never shift.
   always_comb begin
      amt_eff   = AMT_W'(sat_amt(32'(req_amt), 32'(DATA_LEN)));
      zero_step = (req_op == OP_CLR) || (req_op == OP_LOAD)
               || (amt_eff == '0);
   end

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      op_d    = op_q;
      fill_d  = fill_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               op_d    = req_op;
               fill_d  = req_fill;
               data_d  = (req_op == OP_CLR) ? '0 : req_data;
               cnt_d   = zero_step ? '0 : amt_eff;
               state_d = zero_step ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            data_d = step_nxt;
            cnt_d  = cnt_q - AMT_W'(1);
            if (cnt_q == AMT_W'(1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      ready_d = (state_d == S_IDLE);
      valid_d = (state_d == S_DONE);
      busy_d  = (state_d != S_IDLE);
   end

   // State, datapath and output registers with sync reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         op_q    <= OP_CLR;
         fill_q  <= 1'b0;
         cnt_q   <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         op_q    <= op_d;
         fill_q  <= fill_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = valid_q;
   assign rsp_data  = data_q;
   assign busy      = busy_q;

endmodule
